// File: rtl/bufgctrl_switch_ctrl.sv
// bufgctrl_switch_ctrl
// Drives the CE0/CE1/S0/S1 pins of one BUFGCTRL so the global clock can be moved
// between I0 and I1 without glitches. A request accepted in IDLE walks through
// disable old -> settle -> reselect -> enable new -> settle, then pulses done.
// Runs on a free-running fabric clock, never on the clock being switched.
//
// Optional feature macro: BUFGCTRL_SWCNT_EN
//   When defined, adds the sw_count output. It is a 16-bit saturating count of
//   completed real switches, where the target differs from the current source.
module bufgctrl_switch_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 8,   // 1..255
   parameter int unsigned CNT_W         = 8    // must hold SETTLE_CYCLES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_sel,
   output logic        req_ready,
   output logic        ce0,
   output logic        ce1,
   output logic        s0,
   output logic        s1,
   output logic        cur_sel,
   output logic        busy,
`ifdef BUFGCTRL_SWCNT_EN
   output logic [15:0] sw_count,
`endif
   output logic        done
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OFF_WAIT,
      ST_SEL,
      ST_ON_WAIT,
      ST_DONE
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             new_q, new_d;       // target input latched at acceptance
   logic [1:0]       ce_q, ce_d;         // bit n drives CEn
   logic [1:0]       s_q, s_d;           // bit n drives Sn
   logic             cur_q, cur_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic [1:0]       new_onehot;
`ifdef BUFGCTRL_SWCNT_EN
   logic [15:0]      sw_count_q, sw_count_d;
`endif

   // One-hot form of the target, so only one CE or S bit can ever be set.
   assign new_onehot = new_q ? 2'b10 : 2'b01;

   // Next-state and registered-output logic for the switch sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      new_d   = new_q;
      ce_d    = ce_q;
      s_d     = s_q;
      cur_d   = cur_q;
      done_d  = 1'b0;
`ifdef BUFGCTRL_SWCNT_EN
      sw_count_d = sw_count_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_sel != cur_q) begin
                  // Gate the old clock first. Only the old CE can be high here.
                  new_d   = req_sel;
                  ce_d    = 2'b00;
                  cnt_d   = SETTLE_LOAD;
                  state_d = ST_OFF_WAIT;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_OFF_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               s_d     = new_onehot;
               state_d = ST_SEL;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_SEL: begin
            ce_d    = new_onehot;
            cnt_d   = SETTLE_LOAD;
            state_d = ST_ON_WAIT;
         end
         ST_ON_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               done_d  = 1'b1;
               cur_d   = new_q;
               state_d = ST_DONE;
`ifdef BUFGCTRL_SWCNT_EN
               if (sw_count_q != 16'hFFFF) begin
                  sw_count_d = sw_count_q + 16'd1;
               end
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d  = (state_d != ST_IDLE);
      ready_d = (state_d == ST_IDLE);
   end

   // State and output registers. Reset leaves I0 selected and enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         new_q   <= 1'b0;
         ce_q    <= 2'b01;
         s_q     <= 2'b01;
         cur_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         new_q   <= new_d;
         ce_q    <= ce_d;
         s_q     <= s_d;
         cur_q   <= cur_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

`ifdef BUFGCTRL_SWCNT_EN
   // Saturating count of completed real switches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_count_q <= '0;
      end else begin
         sw_count_q <= sw_count_d;
      end
   end

   assign sw_count = sw_count_q;
`endif

   assign ce0       = ce_q[0];
   assign ce1       = ce_q[1];
   assign s0        = s_q[0];
   assign s1        = s_q[1];
   assign cur_sel   = cur_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign req_ready = ready_q;

endmodule

// File: tb/tb_bufgctrl_switch_ctrl.sv
// tb_bufgctrl_switch_ctrl
// Directed and random switch requests for bufgctrl_switch_ctrl. Expected outputs
// come from a timeline model. It maps the number of edges since acceptance to
// the pin values each step of the switch sequence should produce.
// Optional feature macro: BUFGCTRL_SWCNT_EN (also exercises sw_count).
module tb_bufgctrl_switch_ctrl;

   localparam int S = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_sel;
   logic        req_ready, ce0, ce1, s0, s1, cur_sel, busy, done;
`ifdef BUFGCTRL_SWCNT_EN
   logic [15:0] sw_count;
`endif

   int          n_assert = 0;
   int          n_fail   = 0;
   logic        cur_m;           // model: source currently driving the clock
   logic [15:0] cnt_m;           // model: completed real switches

   bufgctrl_switch_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_sel   (req_sel),
      .req_ready (req_ready),
      .ce0       (ce0),
      .ce1       (ce1),
      .s0        (s0),
      .s1        (s1),
      .cur_sel   (cur_sel),
      .busy      (busy),
`ifdef BUFGCTRL_SWCNT_EN
      .sw_count  (sw_count),
`endif
      .done      (done)
   );

   always #5 clk = ~clk;

   // Vector order: {req_ready, busy, done, cur_sel, ce0, ce1, s0, s1}
   function automatic logic [7:0] idle_vec(input logic cur);
      return {1'b1, 1'b0, 1'b0, cur, ~cur, cur, ~cur, cur};
   endfunction

   // Expected outputs after edge t, where edge 0 is the acceptance edge.
   function automatic logic [7:0] seq_vec(input int t, input logic old, input logic nw);
      logic ce_old, ce_new, s_old, s_new, cur, dn, bz, rdy;
      if (nw == old) begin
         ce_old = 1'b1; ce_new = 1'b0; s_old = 1'b1; s_new = 1'b0;
         cur = old; dn = (t == 0); bz = (t == 0); rdy = (t >= 1);
      end else begin
         ce_old = 1'b0;
         ce_new = (t >= S + 1);
         s_new  = (t >= S);
         s_old  = !(t >= S);
         cur    = (t >= 2*S + 1) ? nw : old;
         dn     = (t == 2*S + 1);
         bz     = (t <= 2*S + 1);
         rdy    = (t >= 2*S + 2);
      end
      if (old == 1'b0)
         return {rdy, bz, dn, cur, ce_old, ce_new, s_old, s_new};
      else
         return {rdy, bz, dn, cur, ce_new, ce_old, s_new, s_old};
   endfunction

   task automatic check(input string tag, input logic [7:0] exp);
      logic [7:0] obs;
      obs = {req_ready, busy, done, cur_sel, ce0, ce1, s0, s1};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
`ifdef BUFGCTRL_SWCNT_EN
      n_assert++;
      assert (sw_count === cnt_m) else begin
         n_fail++;
         $error("FAIL %s_sw_count observed=%0h expected=%0h", tag, sw_count, cnt_m);
      end
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         step();
         check(tag, idle_vec(cur_m));
      end
   endtask

   // Issue one request and follow it to completion, or until edge abort_at.
   // With noise set, req_valid/req_sel are scrambled after acceptance.
   task automatic do_req(input logic sel, input bit noise, input int abort_at);
      logic old;
      int   last;
      old       = cur_m;
      last      = (sel == old) ? 1 : 2*S + 2;
      req_valid = 1'b1;
      req_sel   = sel;
      for (int t = 0; t <= last; t++) begin
         step();
         if (sel != old && t == 2*S + 1) begin
            cur_m = sel;
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
         end
         check($sformatf("req_%0d_to_%0d_t%0d", old, sel, t), seq_vec(t, old, sel));
         if (t == abort_at) begin
            req_valid = 1'b0;
            $display("req old=%0d new=%0d aborted after edge %0d", old, sel, t);
            return;
         end
         if (t < last && noise) begin
            req_valid = 1'($urandom_range(0, 1));
            req_sel   = 1'($urandom_range(0, 1));
         end else begin
            req_valid = 1'b0;
         end
      end
      $display("req old=%0d new=%0d noise=%0d done, cur_sel=%0d", old, sel, noise, cur_sel);
   endtask

   // Assert reset between clock edges and check that it acts without a clock.
   task automatic apply_reset(input string tag);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      cur_m     = 1'b0;
      cnt_m     = 16'd0;
      #1;
      check(tag, idle_vec(1'b0));
      n_assert++;
      assert (!(ce0 && ce1) && !(s0 && s1)) else begin
         n_fail++;
         $error("FAIL %s_exclusive observed=%b%b%b%b expected=no_overlap", tag, ce0, ce1, s0, s1);
      end
      step();
      check({tag, "_held"}, idle_vec(1'b0));
      #2;
      rst_n = 1'b1;
      $display("reset %s applied and released", tag);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_sel   = 1'b0;
      cur_m     = 1'b0;
      cnt_m     = 16'd0;
      #12;
      check("reset_state", idle_vec(1'b0));
      rst_n = 1'b1;
      idle_cycles(5, "idle_after_reset");

      do_req(1'b1, 1'b0, -1);           // 0 -> 1 switch, clean inputs
      do_req(1'b1, 1'b0, -1);           // same source while on I1
      do_req(1'b0, 1'b0, -1);           // 1 -> 0 switch
      do_req(1'b0, 1'b0, -1);           // same source while on I0
      idle_cycles(2, "idle_gap");
      do_req(1'b1, 1'b1, -1);           // valid held/toggling during a switch
      idle_cycles(1, "idle_gap");
      do_req(1'b0, 1'b1, -1);

      do_req(1'b1, 1'b0, 9);            // 0 -> 1, reset after edge 9
      apply_reset("mid_switch_reset");
      idle_cycles(2, "idle_after_mid_reset");

      for (int i = 0; i < 12; i++) begin
         idle_cycles($urandom_range(0, 3), "rand_idle");
         do_req(1'($urandom_range(0, 1)), 1'b1, -1);
      end

`ifdef BUFGCTRL_SWCNT_EN
      apply_reset("count_reset");
      idle_cycles(1, "idle_count");
      do_req(1'b1, 1'b0, -1);
      do_req(1'b0, 1'b0, -1);
      do_req(1'b1, 1'b0, -1);
      do_req(1'b1, 1'b0, -1);
      n_assert++;
      assert (sw_count === 16'd3) else begin
         n_fail++;
         $error("FAIL sw_count_three observed=%0h expected=3", sw_count);
      end
      force dut.sw_count_q = 16'hFFFF;
      cnt_m = 16'hFFFF;
      step();
      release dut.sw_count_q;
      idle_cycles(1, "idle_forced");
      do_req(1'b0, 1'b0, -1);
      n_assert++;
      assert (sw_count === 16'hFFFF) else begin
         n_fail++;
         $error("FAIL sw_count_saturate observed=%0h expected=ffff", sw_count);
      end
`endif

      idle_cycles(2, "final_idle");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
